// File: rtl/parking_sensor_frontend_pkg.sv
// Shared constants and helpers for the parking sensor front end.
//   PARK_CAPACITY_DEF : default number of parking slots
//   PARK_DEBOUNCE_DEF : default debounce length in synchronised cycles
//   cnt_width(cap)    : bits needed to hold 0..cap
package parking_pkg;

  localparam int unsigned PARK_CAPACITY_DEF = 8;
  localparam int unsigned PARK_DEBOUNCE_DEF = 4;

  function automatic int unsigned cnt_width(input int unsigned cap);
    return $clog2(cap + 1);
  endfunction

endpackage

// File: rtl/parking_sensor_frontend_if.sv
// Signal bundle between the raw beam sensors, the front end and the gate controller.
//   raw_entrance/raw_exit       : unsynchronised beams, 1 = car present
//   sensor_entrance/sensor_exit : clean presence levels for the controller
//   entry_evt/exit_evt          : one-cycle pulses per counted arrival/departure
//   occupancy/free_slots        : cars inside / slots left
//   lot_full/err_underflow      : full flag / sticky exit-while-empty flag
// master: the front end itself. slave: the sensor/controller side.
interface parking_sensor_frontend_if #(
  parameter int unsigned CNT_W = 4
) ();

  logic             raw_entrance;
  logic             raw_exit;
  logic             sensor_entrance;
  logic             sensor_exit;
  logic             entry_evt;
  logic             exit_evt;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W-1:0] free_slots;
  logic             lot_full;
  logic             err_underflow;

  modport master (
    input  raw_entrance, raw_exit,
    output sensor_entrance, sensor_exit, entry_evt, exit_evt,
           occupancy, free_slots, lot_full, err_underflow
  );

  modport slave (
    output raw_entrance, raw_exit,
    input  sensor_entrance, sensor_exit, entry_evt, exit_evt,
           occupancy, free_slots, lot_full, err_underflow
  );

endinterface

// File: rtl/parking_sensor_frontend_debouncer.sv
// One beam channel: 2-flop synchroniser, debounce counter and rise detect.
//   clk, reset : system clock, asynchronous active-high reset
//   raw_in     : asynchronous beam input
//   clean_out  : debounced level
//   rise_pulse : high for the one cycle after clean_out goes 0 -> 1
module sensor_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic clean_out,
  output logic rise_pulse
);

  localparam logic [7:0] LastCnt = 8'(DEBOUNCE_CYCLES - 1);

  logic [1:0] sync_q;
  logic [7:0] cnt_q, cnt_d;
  logic       clean_q, clean_d;
  logic       prev_q;
  logic       sync;

  assign sync = sync_q[1];

  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    if (sync != clean_q) begin
      if (cnt_q == LastCnt) begin
        clean_d = sync;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_in};
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      prev_q  <= clean_q;
    end
  end

  assign clean_out  = clean_q;
  assign rise_pulse = clean_q & ~prev_q;

endmodule

// File: rtl/parking_sensor_frontend.sv
// Parking gate front end: debounces both beams, counts occupancy and hides entrance
// presence from the controller while the lot is full.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : parking_sensor_frontend_if master (raw beams in, clean levels,
//                events, occupancy, free_slots, lot_full, err_underflow out)
module parking_sensor_frontend
  import parking_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = PARK_DEBOUNCE_DEF,
  parameter int unsigned CAPACITY        = PARK_CAPACITY_DEF,
  localparam int unsigned CNT_W          = cnt_width(CAPACITY)
) (
  input logic                        clk,
  input logic                        reset,
  parking_sensor_frontend_if.master  bus
);

  localparam logic [CNT_W-1:0] Cap = CNT_W'(CAPACITY);

  logic             clean_ent, clean_ex;
  logic             rise_ent, rise_ex;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             supp_q, supp_d;
  logic             err_q, err_d;
  logic             entry_evt_q, exit_evt_q;
  logic             full, empty;
  logic             entry_cnt, exit_cnt;
  logic             supp_eff;

  sensor_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_deb_entrance (
    .clk        (clk),
    .reset      (reset),
    .raw_in     (bus.raw_entrance),
    .clean_out  (clean_ent),
    .rise_pulse (rise_ent)
  );

  sensor_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_deb_exit (
    .clk        (clk),
    .reset      (reset),
    .raw_in     (bus.raw_exit),
    .clean_out  (clean_ex),
    .rise_pulse (rise_ex)
  );

  assign full  = (occ_q == Cap);
  assign empty = (occ_q == '0);

  // Both rises are judged against the pre-update count; an exit on an empty lot is
  // still legal when it pairs with an entry admitted in the same cycle.
  assign entry_cnt = rise_ent & ~full;
  assign exit_cnt  = rise_ex & (~empty | entry_cnt);

  // Fold the pending suppression in so the controller never sees a one-cycle
  // entrance blip on the rise cycle of a car arriving at a full lot.
  assign supp_eff = supp_q | (rise_ent & full);

  always_comb begin
    occ_d = occ_q;
    unique case ({entry_cnt, exit_cnt})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase

    supp_d = supp_q;
    if (!clean_ent) begin
      supp_d = 1'b0;
    end else if (rise_ent && full) begin
      supp_d = 1'b1;
    end

    err_d = err_q | (rise_ex & ~exit_cnt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q       <= '0;
      supp_q      <= 1'b0;
      err_q       <= 1'b0;
      entry_evt_q <= 1'b0;
      exit_evt_q  <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      supp_q      <= supp_d;
      err_q       <= err_d;
      entry_evt_q <= entry_cnt;
      exit_evt_q  <= exit_cnt;
    end
  end

  assign bus.sensor_entrance = clean_ent & ~supp_eff;
  assign bus.sensor_exit     = clean_ex;
  assign bus.entry_evt       = entry_evt_q;
  assign bus.exit_evt        = exit_evt_q;
  assign bus.occupancy       = occ_q;
  assign bus.free_slots      = Cap - occ_q;
  assign bus.lot_full        = full;
  assign bus.err_underflow   = err_q;

endmodule

// File: tb/tb_parking_sensor_frontend.sv
// Directed bench for parking_sensor_frontend with an event scoreboard.
module tb_parking_sensor_frontend;
  import parking_pkg::*;

  localparam int unsigned CNT_W = cnt_width(PARK_CAPACITY_DEF);

  typedef struct {
    logic        is_exit;
    logic [31:0] occ;
  } exp_evt_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  parking_sensor_frontend_if #(.CNT_W(CNT_W)) bus ();

  parking_sensor_frontend #(
    .DEBOUNCE_CYCLES (PARK_DEBOUNCE_DEF),
    .CAPACITY        (PARK_CAPACITY_DEF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int       n_tests = 0;
  int       n_fail  = 0;
  exp_evt_t sb[$];
  logic     ent_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic is_exit, input int occ);
    exp_evt_t e;
    e.is_exit = is_exit;
    e.occ     = occ;
    sb.push_back(e);
  endtask

  task automatic check_evt(input logic is_exit);
    exp_evt_t e;
    n_tests++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL unexpected_evt: observed %s pulse expected none", is_exit ? "exit" : "entry");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("evt_kind", {31'd0, is_exit}, {31'd0, e.is_exit});
      chk("evt_occ", 32'(bus.occupancy), e.occ);
    end
  endtask

  // Scoreboard consumer: every event pulse must match the next expected event.
  always @(negedge clk) begin
    if (bus.entry_evt === 1'b1) check_evt(1'b0);
    if (bus.exit_evt === 1'b1) check_evt(1'b1);
  end

  // Present a car on the selected beams for 'hold' cycles, then clear and settle.
  task automatic car(input logic ent, input logic ex, input int hold);
    ent_seen = 1'b0;
    bus.raw_entrance = ent;
    bus.raw_exit     = ex;
    for (int i = 0; i < hold; i++) begin
      tick(1);
      ent_seen = ent_seen | bus.sensor_entrance;
    end
    bus.raw_entrance = 1'b0;
    bus.raw_exit     = 1'b0;
    tick(12);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    sb.delete();
    reset = 1'b0;
    tick(1);
  endtask

  initial begin
    bus.raw_entrance = 1'b0;
    bus.raw_exit     = 1'b0;
    tick(2);

    // Reset values
    chk("rst_sensor_ent", 32'(bus.sensor_entrance), 0);
    chk("rst_sensor_ex", 32'(bus.sensor_exit), 0);
    chk("rst_entry_evt", 32'(bus.entry_evt), 0);
    chk("rst_exit_evt", 32'(bus.exit_evt), 0);
    chk("rst_occ", 32'(bus.occupancy), 0);
    chk("rst_free", 32'(bus.free_slots), 8);
    chk("rst_full", 32'(bus.lot_full), 0);
    chk("rst_err", 32'(bus.err_underflow), 0);
    reset = 1'b0;
    tick(1);

    // Bounce rejection
    ent_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.raw_entrance = ~bus.raw_entrance;
      tick(1);
      ent_seen = ent_seen | bus.sensor_entrance;
    end
    bus.raw_entrance = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      ent_seen = ent_seen | bus.sensor_entrance;
    end
    chk("bounce_sensor", 32'(ent_seen), 0);
    chk("bounce_occ", 32'(bus.occupancy), 0);

    // Latency: flip after edge 6, event after edge 7
    push(1'b0, 1);
    bus.raw_entrance = 1'b1;
    tick(5);
    chk("lat_edge5", 32'(bus.sensor_entrance), 0);
    tick(1);
    chk("lat_edge6", 32'(bus.sensor_entrance), 1);
    chk("lat_evt_edge6", 32'(bus.entry_evt), 0);
    tick(1);
    chk("lat_evt_edge7", 32'(bus.entry_evt), 1);
    tick(1);
    chk("lat_evt_edge8", 32'(bus.entry_evt), 0);
    chk("lat_occ", 32'(bus.occupancy), 1);
    chk("lat_free", 32'(bus.free_slots), 7);
    tick(12);
    chk("lat_held_occ", 32'(bus.occupancy), 1);
    bus.raw_entrance = 1'b0;
    tick(12);

    // Fill the lot
    for (int i = 2; i <= 8; i++) begin
      push(1'b0, i);
      car(1'b1, 1'b0, 12);
    end
    chk("fill_occ", 32'(bus.occupancy), 8);
    chk("fill_full", 32'(bus.lot_full), 1);
    chk("fill_free", 32'(bus.free_slots), 0);

    // Ninth car: suppressed for its whole presence
    car(1'b1, 1'b0, 14);
    chk("ninth_sensor", 32'(ent_seen), 0);
    chk("ninth_occ", 32'(bus.occupancy), 8);

    // One exit, then the waiting car is admitted
    push(1'b1, 7);
    car(1'b0, 1'b1, 12);
    chk("exit1_occ", 32'(bus.occupancy), 7);
    push(1'b0, 8);
    car(1'b1, 1'b0, 12);
    chk("readmit_occ", 32'(bus.occupancy), 8);

    // Simultaneous rises at full
    push(1'b1, 7);
    ent_seen = 1'b0;
    bus.raw_entrance = 1'b1;
    bus.raw_exit     = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      ent_seen = ent_seen | bus.sensor_entrance;
    end
    chk("simfull_sensor_held", 32'(ent_seen), 0);
    chk("simfull_sensor_ex", 32'(bus.sensor_exit), 1);
    chk("simfull_occ", 32'(bus.occupancy), 7);
    chk("simfull_notfull", 32'(bus.lot_full), 0);
    bus.raw_entrance = 1'b0;
    bus.raw_exit     = 1'b0;
    tick(12);
    push(1'b0, 8);
    car(1'b1, 1'b0, 12);
    chk("simfull_after_sensor", 32'(ent_seen), 1);
    chk("simfull_after_occ", 32'(bus.occupancy), 8);

    // Underflow
    do_reset();
    car(1'b0, 1'b1, 12);
    chk("uflow_occ", 32'(bus.occupancy), 0);
    chk("uflow_err", 32'(bus.err_underflow), 1);
    tick(5);
    chk("uflow_sticky", 32'(bus.err_underflow), 1);
    push(1'b0, 1);
    car(1'b1, 1'b0, 12);
    chk("uflow_entry_occ", 32'(bus.occupancy), 1);
    chk("uflow_entry_err", 32'(bus.err_underflow), 1);

    // Empty lot: simultaneous entry and exit pair up
    do_reset();
    push(1'b0, 0);
    push(1'b1, 0);
    car(1'b1, 1'b1, 12);
    chk("simempty_occ", 32'(bus.occupancy), 0);
    chk("simempty_err", 32'(bus.err_underflow), 0);

    // Reset mid-operation
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      push(1'b0, i);
      car(1'b1, 1'b0, 12);
    end
    chk("midrst_pre_occ", 32'(bus.occupancy), 5);
    bus.raw_entrance = 1'b1;
    tick(2);
    reset = 1'b1;
    #1;
    chk("midrst_occ", 32'(bus.occupancy), 0);
    chk("midrst_free", 32'(bus.free_slots), 8);
    chk("midrst_sensor", 32'(bus.sensor_entrance), 0);
    chk("midrst_full", 32'(bus.lot_full), 0);
    chk("midrst_err", 32'(bus.err_underflow), 0);
    sb.delete();
    push(1'b0, 1);
    @(negedge clk);
    reset = 1'b0;
    tick(5);
    chk("midrst_edge5", 32'(bus.sensor_entrance), 0);
    tick(1);
    chk("midrst_edge6", 32'(bus.sensor_entrance), 1);
    tick(3);
    chk("midrst_post_occ", 32'(bus.occupancy), 1);
    bus.raw_entrance = 1'b0;
    tick(12);

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/parking_sensor_frontend.md
Name: parking_sensor_frontend

Overview:
- Upstream conditioning stage for the parking gate controller.
- Takes raw, bouncy, asynchronous entrance and exit beam sensors and synchronises and debounces them. Produces the clean sensor_entrance / sensor_exit levels the controller consumes.
- Tracks lot occupancy and suppresses entrance presence when the lot is full, so the controller never asks a car for a password it cannot admit.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronised cycles a raw input must differ from its clean value before the clean value flips; legal range 1..255.
- CAPACITY, 8, number of parking slots; at least 1.
- CNT_W, $clog2(CAPACITY+1), width of the occupancy and free-slot counts; derived, not overridden.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- raw_entrance  in  1  unsynchronised entrance beam, 1 = car present
- raw_exit  in  1  unsynchronised exit beam, 1 = car present
- sensor_entrance  out  1  clean entrance presence, gated by full-suppression; feeds controller
- sensor_exit  out  1  clean exit presence; feeds controller
- entry_evt  out  1  one-cycle pulse per counted arrival
- exit_evt  out  1  one-cycle pulse per counted departure
- occupancy  out  CNT_W  cars currently inside
- free_slots  out  CNT_W  CAPACITY - occupancy
- lot_full  out  1  occupancy == CAPACITY
- err_underflow  out  1  sticky; exit seen while occupancy == 0

Behaviour:
- Reset values:
  - All registers clear, including synchroniser flops and debounce counters.
  - sensor_entrance = 0, sensor_exit = 0, entry_evt = 0, exit_evt = 0.
  - occupancy = 0, free_slots = CAPACITY, lot_full = 0, err_underflow = 0.
- Reset mid-operation clears everything at once. A raw input held high through reset deassertion is re-debounced from scratch.
- Synchroniser: 2 flops per raw input.
- Debounce, per channel:
  - Counter increments each cycle the synchronised value differs from the clean value.
  - Counter clears to 0 on any cycle they match.
  - When it differs and the counter == DEBOUNCE_CYCLES-1, the clean value flips and the counter clears.
- Debounce latency: number the first edge that samples a stable new raw value as edge 1. The clean value flips on edge DEBOUNCE_CYCLES+2. With the default, edge 6.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no clean change.
- Edge detect: registered previous clean value per channel.
  - A rise is clean=1 and prev=0; it is evaluated combinationally in the cycle after the clean flip.
  - Events, occupancy and suppression all update on the edge that follows the rise.
  - entry_evt and exit_evt are asserted for exactly the one cycle following that edge.
- Entrance rise:
  - If lot_full = 0: set entry_evt and increment occupancy.
  - If lot_full = 1: set suppress, no entry_evt, no increment.
- Suppress: while set, sensor_entrance = 0. It clears on the edge where clean entrance is 0.
- sensor_entrance = clean_entrance AND NOT suppress. This is combinational from registers and has no extra latency.
- Exit rise:
  - If occupancy > 0: set exit_evt and decrement occupancy.
  - If occupancy = 0: no exit_evt, set err_underflow (sticky until reset).
- sensor_exit = clean_exit. It is never gated.
- Simultaneous entrance and exit rise in the same cycle: evaluate both against the pre-update occupancy.
  - Counted entry plus counted exit: occupancy unchanged, both events pulse.
  - Full lot plus exit: entrance suppressed; exit counted; occupancy = CAPACITY-1.
  - Empty lot plus entry: both events pulse, occupancy stays 0, err_underflow is NOT set. The exit is paired with the admitted car.
- Arithmetic: occupancy saturates at both 0 and CAPACITY and never wraps. free_slots and lot_full are combinational from occupancy.
- A car that stays in the beam produces one event only; a new event needs a clean fall then a rise.

Decomposition:
- Shared package parking_pkg holds:
  - constant PARK_CAPACITY_DEF = 8;
  - constant PARK_DEBOUNCE_DEF = 4;
  - function cnt_width(cap) returning $clog2(cap+1).
- One sub-module, sensor_debouncer (parameter DEBOUNCE_CYCLES; ports clk, reset, raw_in, clean_out, rise_pulse). It contains the synchroniser, counter and edge detect, and is instantiated twice.
- Occupancy, suppression and error logic stay in the top.

Test Plan:
- Bounce rejection: after reset, toggle raw_entrance 1/0 every cycle for 10 cycles, then hold 0 -> sensor_entrance stays 0, entry_evt never pulses, occupancy = 0.
- Latency: raise raw_entrance and hold for 20 cycles with DEBOUNCE_CYCLES = 4 -> sensor_entrance rises on edge 6; entry_evt is a single-cycle pulse in the following cycle; occupancy = 1; free_slots = 7.
- Fill and suppress: admit 8 cars, then present a ninth -> lot_full = 1, occupancy = 8, sensor_entrance stays 0 for the whole ninth presence, no entry_evt.
  - Release the beam, then present again after one exit -> car counted, occupancy = 8.
- Simultaneous at full: with occupancy = 8, make the clean entrance and exit rises land in the same cycle -> exit_evt pulses, entry_evt does not, occupancy = 7, sensor_entrance stays 0 until the entrance beam clears.
- Underflow: from reset, present an exit -> exit_evt never pulses, occupancy = 0, err_underflow = 1 and stays 1.
  - A subsequent entry gives occupancy = 1 with err_underflow still 1.
- Reset mid-operation: with occupancy = 5 and raw_entrance held high, assert reset for 1 cycle -> all outputs return to reset values immediately; after release, sensor_entrance re-rises 6 edges later and occupancy = 1.
